// File: rtl/decoder_3x8_stream.sv
// decoder_3x8_stream: valid/ready 3-to-8 one-hot decoder with autonomous scan mode.
// Define DECODER_3X8_PARITY_EN to add even-parity checking of stream codes (in_par, err, err_cnt).
module decoder_3x8_stream #(
  parameter int DWELL_W = 8,
  parameter int WRAP_LAST = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out,
  input  logic               scan_mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic               busy
`ifdef DECODER_3X8_PARITY_EN
  ,
  input  logic               in_par,
  output logic               err,
  output logic [7:0]         err_cnt
`endif
);
  typedef enum logic {STREAM, SCAN} state_t;
  state_t state;
  logic [2:0] scan_idx;
  logic [DWELL_W-1:0] dwell_cnt;
  logic slot_free, accept, par_ok, stream_load, scan_load;
  assign slot_free = !out_valid || out_ready;
  assign in_ready = en && slot_free && !scan_mode && state == STREAM;
  assign accept = in_valid && in_ready;
`ifdef DECODER_3X8_PARITY_EN
  assign par_ok = !(^{in, in_par});
`else
  assign par_ok = 1'b1;
`endif
  assign stream_load = accept && par_ok;
  // >= so a dwell shrunk below the running count fires on the next free slot
  assign scan_load = state == SCAN && en && scan_mode && slot_free && dwell_cnt >= dwell;
  assign busy = state == SCAN || out_valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out <= 8'h00;
      out_valid <= 1'b0;
      state <= STREAM;
      scan_idx <= 3'd0;
      dwell_cnt <= '0;
    end else begin
      out_valid <= stream_load || scan_load || (out_valid && !out_ready);
      if (stream_load || scan_load) out <= 8'd1 << (scan_load ? scan_idx : in);
      if (en) begin
        if (state == STREAM && scan_mode) begin
          state <= SCAN;
          scan_idx <= 3'd0;
          dwell_cnt <= '0;
        end else if (state == SCAN && !scan_mode) state <= STREAM;
        else if (scan_load) begin
          scan_idx <= (scan_idx == 3'(WRAP_LAST)) ? 3'd0 : scan_idx + 3'd1;
          dwell_cnt <= '0;
        end else if (state == SCAN && dwell_cnt < dwell) dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
`ifdef DECODER_3X8_PARITY_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      err <= 1'b0;
      err_cnt <= 8'h00;
    end else begin
      err <= accept && !par_ok;
      if (accept && !par_ok && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_decoder_3x8_stream.sv
// tb_decoder_3x8_stream: scoreboard bench for the stream decoder, scan mode and reset behaviour.
module tb_decoder_3x8_stream;
  logic clk = 0, rst = 1, en = 1, in_valid = 0, out_ready = 1, scan_mode = 0;
  logic [2:0] code = 0;
  logic [7:0] dwell = 0;
  logic in_ready, out_valid, busy;
  logic [7:0] out;
  logic scan_mode2 = 0;
  logic in_ready2, out_valid2, busy2;
  logic [7:0] out2;
`ifdef DECODER_3X8_PARITY_EN
  logic in_par = 0, err, err2;
  logic [7:0] err_cnt, err_cnt2;
`endif
  int vectors = 0, miscompares = 0, cyc = 0;
  logic [7:0] exp_q[$];
  int pop_cyc[$];
  logic [7:0] dec_tab[8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] wrap_tab[5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01};

  decoder_3x8_stream dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready), .in(code),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .scan_mode(scan_mode),
    .dwell(dwell), .busy(busy)
`ifdef DECODER_3X8_PARITY_EN
    , .in_par(in_par), .err(err), .err_cnt(err_cnt)
`endif
  );

  decoder_3x8_stream #(.DWELL_W(8), .WRAP_LAST(3)) dut2 (
    .clk(clk), .rst(rst), .en(1'b1), .in_valid(1'b0), .in_ready(in_ready2), .in(3'd0),
    .out_valid(out_valid2), .out_ready(1'b1), .out(out2), .scan_mode(scan_mode2),
    .dwell(8'd0), .busy(busy2)
`ifdef DECODER_3X8_PARITY_EN
    , .in_par(1'b0), .err(err2), .err_cnt(err_cnt2)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_code(input logic [2:0] v);
    code = v;
`ifdef DECODER_3X8_PARITY_EN
    in_par = ^v;
`endif
  endtask

  task automatic wait_size(input string name, input int target, input int limit);
    int n = 0;
    while (exp_q.size() > target && n < limit) begin
      step();
      n++;
    end
    chk(name, exp_q.size(), target);
  endtask

  // monitor: retire beats against the queue, record input handshakes as expected beats
  always @(negedge clk) begin
    logic par_good;
    par_good = 1'b1;
`ifdef DECODER_3X8_PARITY_EN
    par_good = !(^{code, in_par});
`endif
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got %0h expected none", out);
      end else begin
        chk("scoreboard", out, exp_q.pop_front());
        pop_cyc.push_back(cyc);
      end
    end
    if (in_valid && in_ready && par_good) exp_q.push_back(dec_tab[code]);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    #12;
    chk("reset_out", out, 8'h00);
    chk("reset_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst = 0;
    step();
    // back-to-back stream, one cycle latency
    for (int i = 0; i < 8; i++) begin
      in_valid = 1;
      set_code(3'(i));
      #1 chk("stream_in_ready", in_ready, 1);
      step();
      chk("stream_latency", out, dec_tab[i]);
    end
    in_valid = 0;
    step();
    step();
    // backpressure hold
    out_ready = 0;
    in_valid = 1;
    set_code(3'd5);
    step();
    set_code(3'd2);
    for (int i = 0; i < 4; i++) begin
      chk("hold_out", out, 8'h20);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1;
    #1 chk("release_in_ready", in_ready, 1);
    step();
    chk("release_next", out, 8'h04);
    in_valid = 0;
    step();
    step();
    // scan, dwell 2: nine beats every 3 cycles, wrapping after 8'h80
    for (int i = 0; i < 9; i++) exp_q.push_back(dec_tab[i % 8]);
    s = pop_cyc.size();
    dwell = 2;
    scan_mode = 1;
    wait_size("scan_drain", 0, 200);
    scan_mode = 0;
    step();
    step();
    for (int k = 1; k < 9; k++) chk("scan_gap", pop_cyc[s + k] - pop_cyc[s + k - 1], 3);
    // scan with a 10-cycle stall mid-sequence
    for (int i = 0; i < 8; i++) exp_q.push_back(dec_tab[i]);
    dwell = 1;
    scan_mode = 1;
    wait_size("stall_pre", 5, 100);
    out_ready = 0;
    repeat (10) step();
    chk("stall_valid", out_valid, 1);
    chk("stall_busy", busy, 1);
    out_ready = 1;
    wait_size("stall_drain", 0, 100);
    scan_mode = 0;
    step();
    step();
    // dwell shrinks from 5 to 0 mid-dwell
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    dwell = 5;
    scan_mode = 1;
    wait_size("dwell_first", 1, 100);
    step();
    dwell = 0;
    step();
    chk("dwell_change_valid", out_valid, 1);
    chk("dwell_change_out", out, 8'h02);
    scan_mode = 0;
    wait_size("dwell_drain", 0, 10);
    step();
    // async reset while a scan beat is held
    out_ready = 0;
    scan_mode = 1;
    step();
    step();
    step();
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1;
    #1;
    chk("async_rst_out", out, 8'h00);
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    dwell = 1;
    out_ready = 1;
    exp_q.push_back(8'h01);
    rst = 0;
    wait_size("post_rst_scan", 0, 50);
    scan_mode = 0;
    step();
    step();
    // en=0 freezes acceptance
    en = 0;
    in_valid = 1;
    set_code(3'd1);
    #1 chk("en0_in_ready", in_ready, 0);
    step();
    chk("en0_no_load", out_valid, 0);
    in_valid = 0;
    en = 1;
    step();
    // WRAP_LAST=3 instance, dwell 0
    scan_mode2 = 1;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("wrap3_out", out2, wrap_tab[k]);
      chk("wrap3_valid", out_valid2, 1);
    end
    scan_mode2 = 0;
    step();
`ifdef DECODER_3X8_PARITY_EN
    in_valid = 1;
    code = 3'b011;
    in_par = 1;
    step();
    in_valid = 0;
    chk("par_err", err, 1);
    chk("par_err_cnt", err_cnt, 1);
    chk("par_no_valid", out_valid, 0);
    step();
    chk("par_err_pulse", err, 0);
    in_valid = 1;
    in_par = 0;
    step();
    in_valid = 0;
    chk("par_good_out", out, 8'h08);
    step();
    in_valid = 1;
    in_par = 1;
    repeat (300) step();
    in_valid = 0;
    step();
    chk("par_saturate", err_cnt, 8'hFF);
`endif
    step();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
